// File: rtl/xcorr_pair_engine_if.sv
// Sample-in / correlation-out handshake bundle for one mic-pair correlation engine.
// master drives samples and out_ready; slave (the engine) drives the rest.
interface xcorr_pair_engine_if #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned N_LAGS   = 128,
  parameter int unsigned OUT_W    = 32
);
  localparam int unsigned LagW = $clog2(N_LAGS);

  logic                       in_valid;
  logic                       in_ready;
  logic signed [SAMPLE_W-1:0] in_a;
  logic signed [SAMPLE_W-1:0] in_b;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [OUT_W-1:0]    out_data;
  logic [LagW-1:0]            out_lag;
  logic                       out_last;
  logic                       busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_lag, out_last, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_lag, out_last, busy
  );
endinterface

// File: rtl/xcorr_pair_engine.sv
// Frame capture plus serial single-MAC lagged cross-correlation of two mic streams.
// Define XCORR_SAT_EN to saturate the shifted result to OUT_W bits instead of wrapping.
module xcorr_pair_engine #(
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned N_SAMPLES = 128,
  parameter int unsigned N_LAGS    = 128,
  parameter int unsigned LAG_OFS   = 64,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned OUT_SHIFT = 8
) (
  input logic                clk,
  input logic                rst_n,
  xcorr_pair_engine_if.slave bus
);
  localparam int unsigned AddrW = $clog2(N_SAMPLES);
  localparam int unsigned CntW  = $clog2(N_SAMPLES + 3);
  localparam int unsigned LagW  = $clog2(N_LAGS);
  localparam int unsigned ProdW = 2 * SAMPLE_W;

  typedef enum logic [1:0] {StLoad, StCompute, StPresent} state_e;

  state_e                     state_q, state_d;
  logic                       rdy_q;
  logic [AddrW-1:0]           wr_q;
  logic [CntW-1:0]            cnt_q;
  logic [LagW-1:0]            k_q;
  logic signed [SAMPLE_W-1:0] a_mem [N_SAMPLES];
  logic signed [SAMPLE_W-1:0] b_mem [N_SAMPLES];
  logic signed [SAMPLE_W-1:0] a_rd_q, b_rd_q;
  logic                       v1_q, v2_q;
  logic signed [ProdW-1:0]    prod_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [OUT_W-1:0]    out_q;
  logic signed [OUT_W-1:0]    reduced;

  logic in_hs, out_hs, last_in, cnt_done, last_lag, b_ok;
  int   b_pos;

  assign in_hs    = rdy_q & bus.in_valid;
  assign out_hs   = (state_q == StPresent) & bus.out_ready;
  assign last_in  = in_hs && (wr_q == AddrW'(N_SAMPLES - 1));
  assign cnt_done = cnt_q == CntW'(N_SAMPLES + 2);
  assign last_lag = k_q == LagW'(N_LAGS - 1);
  // b index for the sample currently being read; outside the frame it contributes zero
  assign b_pos    = int'(cnt_q) + int'(k_q) - int'(LAG_OFS);
  assign b_ok     = (b_pos >= 0) && (b_pos < int'(N_SAMPLES));

`ifdef XCORR_SAT_EN
  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;
  assign shifted = acc_q >>> OUT_SHIFT;

  always_comb begin
    reduced = OUT_W'(shifted);
    if (shifted > SatMax)      reduced = OUT_W'(SatMax);
    else if (shifted < SatMin) reduced = OUT_W'(SatMin);
  end
`else
  assign reduced = OUT_W'(acc_q >>> OUT_SHIFT);
`endif

  // State register; in_ready is registered so it stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d == StLoad;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (last_in) state_d = StCompute;
      StCompute: if (cnt_done) state_d = StPresent;
      StPresent: if (out_hs) state_d = last_lag ? StLoad : StCompute;
      default:   state_d = StLoad;
    endcase
  end

  always_comb begin
    bus.in_ready  = rdy_q;
    bus.out_valid = state_q == StPresent;
    bus.busy      = state_q != StLoad;
    bus.out_last  = (state_q == StPresent) && last_lag;
    bus.out_data  = out_q;
    bus.out_lag   = k_q;
  end

  // Sample buffers carry no reset; they are always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      a_mem[wr_q] <= bus.in_a;
      b_mem[wr_q] <= bus.in_b;
    end
  end

  // Read -> multiply -> accumulate -> output register pipeline, N_SAMPLES+3 cycles per lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      cnt_q  <= '0;
      k_q    <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      a_rd_q <= '0;
      b_rd_q <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      out_q  <= '0;
    end else begin
      if (in_hs) wr_q <= last_in ? '0 : wr_q + 1'b1;
      cnt_q  <= (state_q == StCompute && !cnt_done) ? cnt_q + 1'b1 : '0;
      if (out_hs) k_q <= last_lag ? '0 : k_q + 1'b1;
      v1_q   <= (state_q == StCompute) && (cnt_q < CntW'(N_SAMPLES));
      a_rd_q <= a_mem[cnt_q[AddrW-1:0]];
      b_rd_q <= b_ok ? b_mem[AddrW'(b_pos)] : '0;
      v2_q   <= v1_q;
      prod_q <= ProdW'(a_rd_q) * ProdW'(b_rd_q);
      if (state_q == StCompute && cnt_q == '0) acc_q <= '0;
      else if (v2_q)                             acc_q <= acc_q + ACC_W'(prod_q);
      if (state_q == StCompute && cnt_done) out_q <= reduced;
    end
  end
endmodule

// File: tb/tb_xcorr_pair_engine.sv
// Self-checking bench for xcorr_pair_engine: directed frames plus random data against a
// direct-sum correlation model.
module tb_xcorr_pair_engine;
  localparam int SAMPLE_W  = 16;
  localparam int N         = 128;
  localparam int NL        = 128;
  localparam int LAG_OFS   = 64;
  localparam int ACC_W     = 40;
  localparam int OUT_W     = 32;
  localparam int OUT_SHIFT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xcorr_pair_engine_if #(.SAMPLE_W(SAMPLE_W), .N_LAGS(NL), .OUT_W(OUT_W)) bus ();

  xcorr_pair_engine #(
    .SAMPLE_W (SAMPLE_W),
    .N_SAMPLES(N),
    .N_LAGS   (NL),
    .LAG_OFS  (LAG_OFS),
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int fa[N], fb[N], ga[N], gb[N];
  logic [OUT_W-1:0] exp_r[NL];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // r[k] = sum_n a[n]*b[n+k-LAG_OFS], out-of-frame terms are zero
  task automatic model(input int a[N], input int b[N]);
    for (int k = 0; k < NL; k++) begin
      longint s;
      s = 0;
      for (int n = 0; n < N; n++) begin
        int m;
        m = n + k - LAG_OFS;
        if (m >= 0 && m < N) s += longint'(a[n]) * longint'(b[m]);
      end
      s = s >>> OUT_SHIFT;
`ifdef XCORR_SAT_EN
      if (s > (longint'(1) << (OUT_W - 1)) - 1) s = (longint'(1) << (OUT_W - 1)) - 1;
      if (s < -(longint'(1) << (OUT_W - 1)))    s = -(longint'(1) << (OUT_W - 1));
`endif
      exp_r[k] = s[OUT_W-1:0];
    end
  endtask

  task automatic fill_random(output int a[N], output int b[N]);
    for (int n = 0; n < N; n++) begin
      a[n] = int'(shortint'($urandom));
      b[n] = int'(shortint'($urandom));
      if ($urandom_range(0, 7) == 0) a[n] = -32768;
      if ($urandom_range(0, 7) == 0) b[n] = 32767;
    end
  endtask

  task automatic send(input int a[N], input int b[N], input bit hold, input int na, input int nb);
    int  i;
    int  edges;
    bit  rdy;
    i = 0;
    edges = 0;
    while (i < N && edges < 4 * N) begin
      bus.in_valid = 1'b1;
      bus.in_a     = SAMPLE_W'(a[i]);
      bus.in_b     = SAMPLE_W'(b[i]);
      rdy          = bus.in_ready;
      @(posedge clk);
      #1;
      edges++;
      if (rdy) i++;
    end
    chk("load_edges", 64'(edges), 64'(N));
    if (hold) begin
      bus.in_a = SAMPLE_W'(na);
      bus.in_b = SAMPLE_W'(nb);
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic recv(input int stall_k, input int abort_k);
    int               lat;
    logic [OUT_W-1:0] got, held;
    for (int k = 0; k < NL; k++) begin
      if (k == abort_k) begin
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(bus.out_valid), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_ready", 64'(bus.in_ready), 64'(0));
        chk("abort_lag", 64'(bus.out_lag), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_release_ready", 64'(bus.in_ready), 64'(1));
        return;
      end
      lat = 0;
      while (!bus.out_valid && lat < 300) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("latency", 64'(lat), 64'(N + 3));
      if (!bus.out_valid) return;
      held = bus.out_data;
      chk("data", 64'(held), 64'(exp_r[k]));
      chk("lag", 64'(bus.out_lag), 64'(k));
      chk("last", 64'(bus.out_last), 64'(k == NL - 1));
      chk("busy", 64'(bus.busy), 64'(1));
      chk("in_ready_low", 64'(bus.in_ready), 64'(0));
      if (k == stall_k) begin
        bus.out_ready = 1'b0;
        repeat (50) begin
          @(posedge clk);
          #1;
          got = bus.out_data;
          chk("stall_valid", 64'(bus.out_valid), 64'(1));
          chk("stall_data", 64'(got), 64'(held));
          chk("stall_lag", 64'(bus.out_lag), 64'(k));
        end
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("post_hs_valid", 64'(bus.out_valid), 64'(0));
    end
    chk("frame_end_ready", 64'(bus.in_ready), 64'(1));
    chk("frame_end_busy", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset values
    #7;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(unsigned'(bus.out_data)), 64'(0));
    chk("rst_out_lag", 64'(bus.out_lag), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'(1));

    // Constant frame with a 50-cycle stall on lag 5
    for (int n = 0; n < N; n++) begin
      fa[n] = 100;
      fb[n] = 100;
    end
    model(fa, fb);
    send(fa, fb, 1'b0, 0, 0);
    recv(5, -1);

    // Random frame aborted by reset while lag 30 is computing
    fill_random(fa, fb);
    model(fa, fb);
    send(fa, fb, 1'b0, 0, 0);
    recv(-1, 30);

    // Impulse frame after the abort
    for (int n = 0; n < N; n++) begin
      fa[n] = 0;
      fb[n] = 0;
    end
    fa[10] = 1000;
    fb[20] = 1000;
    model(fa, fb);
    send(fa, fb, 1'b0, 0, 0);
    recv(-1, -1);

    // Back-to-back random frames with in_valid held high throughout
    fill_random(fa, fb);
    fill_random(ga, gb);
    model(fa, fb);
    send(fa, fb, 1'b1, ga[0], gb[0]);
    recv(-1, -1);
    send(ga, gb, 1'b0, 0, 0);
    model(ga, gb);
    recv(-1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
